sqrt_uint_iter: RTL and testbench



---
 rtl/sqrt_uint_iter.sv | 176 +++++++++++++++++
 tb/tb_sqrt_uint_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_uint_iter.sv
// Iterative unsigned integer square root (restoring, digit-by-digit), valid/ready on both sides.
// Optional round-to-nearest root output when SQRT_ROUND_EN is defined.

module sqrt_step #(
    parameter int N = 16
) (
    input  logic [N+1:0] rem_i,
    input  logic [N-1:0] root_i,
    input  logic [1:0]   pair,
    output logic [N+1:0] rem_o,
    output logic [N-1:0] root_o
);
    logic [N+1:0] rem_sh;
    logic [N+1:0] trial;
    logic         ge;

    // The partial remainder never exceeds 2*root+1, so the top two bits drop safely.
    always_comb begin
        rem_sh = {rem_i[N-1:0], pair};
        trial  = {root_i, 2'b01};
        ge     = (rem_sh >= trial);
        rem_o  = ge ? (rem_sh - trial) : rem_sh;
        root_o = {root_i[N-2:0], ge};
    end
endmodule

module sqrt_uint_iter #(
    parameter int WIDTH          = 32,
    parameter int ITER_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   y,
    output logic [WIDTH/2:0]     rem,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 busy
);
    localparam int N  = WIDTH / 2;
    localparam int K  = N / ITER_PER_CYCLE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int I  = ITER_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, CALC, DONE, RND} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   xs;
    logic [N+1:0]       rem_acc;
    logic [N-1:0]       root_acc;
    logic [CW-1:0]      cnt;
    logic [TAG_W-1:0]   tag_r;
    logic [N-1:0]       y_q;
    logic [N:0]         rem_q;
    logic [TAG_W-1:0]   tag_q;
    logic               cnt_done;

    logic [I:0][N+1:0]  rem_c;
    logic [I:0][N-1:0]  root_c;

    assign rem_c[0]  = rem_acc;
    assign root_c[0] = root_acc;
    assign cnt_done  = (cnt == '0);

    // One step per instance; pairs of xs consumed MSB first.
    for (genvar i = 0; i < I; i++) begin : g_step
        sqrt_step #(.N(N)) u_step (
            .rem_i  (rem_c[i]),
            .root_i (root_c[i]),
            .pair   (xs[WIDTH-1-2*i -: 2]),
            .rem_o  (rem_c[i+1]),
            .root_o (root_c[i+1])
        );
    end

`ifdef SQRT_ROUND_EN
    logic         round_up;
    logic [N-1:0] y_rnd;
    // rem > root means x lies past (root+0.5)^2; ties are impossible for integers.
    always_comb begin
        round_up = (rem_acc > {2'b00, root_acc});
        y_rnd    = (round_up && !(&root_acc)) ? root_acc + 1'b1 : root_acc;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
`ifdef SQRT_ROUND_EN
                if (cnt_done) state_d = RND;
`else
                if (cnt_done) state_d = DONE;
`endif
            end
            RND: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs       <= '0;
            rem_acc  <= '0;
            root_acc <= '0;
            cnt      <= '0;
            tag_r    <= '0;
            y_q      <= '0;
            rem_q    <= '0;
            tag_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xs       <= x;
                        tag_r    <= tag_in;
                        rem_acc  <= '0;
                        root_acc <= '0;
                        cnt      <= CW'(K - 1);
                    end
                end
                CALC: begin
                    xs       <= xs << (2 * I);
                    rem_acc  <= rem_c[I];
                    root_acc <= root_c[I];
                    cnt      <= cnt - 1'b1;
`ifndef SQRT_ROUND_EN
                    if (cnt_done) begin
                        y_q   <= root_c[I];
                        rem_q <= rem_c[I][N:0];
                        tag_q <= tag_r;
                    end
`endif
                end
`ifdef SQRT_ROUND_EN
                RND: begin
                    y_q   <= y_rnd;
                    rem_q <= rem_acc[N:0];
                    tag_q <= tag_r;
                end
`endif
                default: ;
            endcase
        end
    end

    assign y       = y_q;
    assign rem     = rem_q;
    assign tag_out = tag_q;
endmodule

// File: tb/tb_sqrt_uint_iter.sv
// Directed bench for sqrt_uint_iter: defaults, backpressure, reset abort, small and wide configs.
module tb_sqrt_uint_iter;
`ifdef SQRT_ROUND_EN
    localparam int LAT = 17, LAT_S = 3, LAT_B = 9;
`else
    localparam int LAT = 16, LAT_S = 2, LAT_B = 8;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    // default configuration
    logic        in_valid = 0, out_ready = 1;
    logic [31:0] x = 0;
    logic [3:0]  tag_in = 0, tag_out;
    logic        in_ready, out_valid, busy;
    logic [15:0] y;
    logic [16:0] rem;

    sqrt_uint_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .y(y), .rem(rem),
        .tag_out(tag_out), .busy(busy)
    );

    // WIDTH=8, ITER_PER_CYCLE=2
    logic       s_iv = 0, s_or = 1, s_ir, s_ov, s_busy;
    logic [7:0] s_x = 0;
    logic [3:0] s_ti = 0, s_to;
    logic [3:0] s_y;
    logic [4:0] s_rem;

    sqrt_uint_iter #(.WIDTH(8), .ITER_PER_CYCLE(2), .TAG_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .x(s_x),
        .tag_in(s_ti), .out_valid(s_ov), .out_ready(s_or), .y(s_y), .rem(s_rem),
        .tag_out(s_to), .busy(s_busy)
    );

    // WIDTH=64, ITER_PER_CYCLE=4
    logic        b_iv = 0, b_or = 1, b_ir, b_ov, b_busy;
    logic [63:0] b_x = 0;
    logic [3:0]  b_ti = 0, b_to;
    logic [31:0] b_y;
    logic [32:0] b_rem;

    sqrt_uint_iter #(.WIDTH(64), .ITER_PER_CYCLE(4), .TAG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .x(b_x),
        .tag_in(b_ti), .out_valid(b_ov), .out_ready(b_or), .y(b_y), .rem(b_rem),
        .tag_out(b_to), .busy(b_busy)
    );

    int total = 0, bad = 0;
    int lat;
    logic ir_seen;

    task automatic chk(input string tagn, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tagn, obs, exp);
        end
    endtask

    // From just after the acceptance edge, count edges until out_valid.
    task automatic wait_out(output int l);
        l = 0;
        ir_seen = 1'b0;
        while (!out_valid && l < 100) begin
            if (in_ready || !busy) ir_seen = 1'b1;
            @(posedge clk); #1;
            l++;
        end
        if (in_ready) ir_seen = 1'b1;
    endtask

    task automatic run(input logic [31:0] xv, input logic [3:0] tv, output int l);
        x = xv; tag_in = tv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(l);
    endtask

    logic [127:0] xx, rr, ye;
    logic ok;

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
        chk("rst_rem", rem, 0);
        chk("rst_tag", tag_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // basic, out_ready=1
        chk("pre_in_ready", in_ready, 1);
        run(32'd1000000, 4'd3, lat);
        chk("lat_1e6", lat, LAT);
        chk("y_1e6", y, 1000);
        chk("rem_1e6", rem, 0);
        chk("tag_1e6", tag_out, 3);
        chk("busy_calc", ir_seen, 0);
        @(posedge clk); #1;
        chk("pulse_1e6", out_valid, 0);
        chk("idle_ready", in_ready, 1);

        run(32'd0, 4'd1, lat);
        chk("y_0", y, 0);
        chk("rem_0", rem, 0);
        @(posedge clk); #1;
        run(32'hFFFFFFFF, 4'd2, lat);
        chk("y_max", y, 65535);
        chk("rem_max", rem, 131070);
        @(posedge clk); #1;
        run(32'd99, 4'd4, lat);
`ifdef SQRT_ROUND_EN
        chk("y_99", y, 10);
`else
        chk("y_99", y, 9);
`endif
        chk("rem_99", rem, 18);
        chk("ready_low_99", ir_seen, 0);
        @(posedge clk); #1;
        run(32'd90, 4'd7, lat);
        chk("y_90", y, 9);
        chk("rem_90", rem, 9);
        @(posedge clk); #1;
        run(32'd91, 4'd8, lat);
`ifdef SQRT_ROUND_EN
        chk("y_91", y, 10);
`else
        chk("y_91", y, 9);
`endif
        chk("rem_91", rem, 10);
        @(posedge clk); #1;

        // backpressure
        out_ready = 1'b0;
        run(32'd99, 4'd5, lat);
        chk("bp_lat", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin x = 32'd16; tag_in = 4'd6; in_valid = 1'b1; end
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_rem", rem, 18);
            chk("bp_tag", tag_out, 5);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp2_lat", lat, LAT);
        chk("bp2_y", y, 4);
        chk("bp2_tag", tag_out, 6);
        @(posedge clk); #1;

        // reset mid-CALC
        x = 32'd1000000; tag_in = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_y", y, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run(32'd16, 4'd10, lat);
        chk("post_lat", lat, LAT);
        chk("post_y", y, 4);
        chk("post_rem", rem, 0);
        @(posedge clk); #1;

        // WIDTH=8, ITER_PER_CYCLE=2
        s_x = 8'd255; s_ti = 4'd11; s_iv = 1'b1;
        @(posedge clk); #1;
        s_iv = 1'b0; lat = 0;
        while (!s_ov && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("s_lat", lat, LAT_S);
        chk("s_y", s_y, 15);
        chk("s_rem", s_rem, 30);
        chk("s_tag", s_to, 11);
        @(posedge clk); #1;

        // WIDTH=64, ITER_PER_CYCLE=4, random operands against the defining inequalities
        for (int n = 0; n < 300; n++) begin
            if (n == 0)      b_x = 64'hFFFF_FFFF_FFFF_FFFF;
            else if (n == 1) b_x = 64'd0;
            else if (n == 2) b_x = 64'd4294967296;
            else             b_x = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            b_iv = 1'b1;
            @(posedge clk); #1;
            b_iv = 1'b0; lat = 0;
            while (!b_ov && lat < 100) begin @(posedge clk); #1; lat++; end
            xx = {64'd0, b_x};
            rr = {96'd0, b_y};
            if (rr * rr > xx) rr = rr - 1;
            ok = (lat == LAT_B) && (rr * rr <= xx) && ((rr + 1) * (rr + 1) > xx)
                 && ({95'd0, b_rem} == xx - rr * rr);
`ifdef SQRT_ROUND_EN
            ye = ({95'd0, b_rem} > rr && rr != 128'hFFFF_FFFF) ? rr + 1 : rr;
`else
            ye = rr;
`endif
            ok = ok && ({96'd0, b_y} == ye);
            chk("b_rand", ok, 1);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
